// File: rtl/float_norm_pack.sv
// Post-add normalizer: renormalizes the raw mantissa sum, adjusts the exponent, packs IEEE-754.
// Define FLOAT_NORM_LZC_EN for a single-cycle leading-zero-count shifter instead of the iterative one.
module float_norm_pack #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 23
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic                     in_sign,
    input  logic [EXP_W-1:0]         in_exp,
    input  logic [MAN_W+1:0]         in_mant,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [EXP_W+MAN_W:0]     out_num,
    output logic                     out_ovf,
    output logic                     out_unf
);

    localparam int unsigned NUM_W = 1 + EXP_W + MAN_W;
    localparam int unsigned MW    = MAN_W + 2;

    typedef enum logic [1:0] {IDLE, NORM, DONE} state_t;

    state_t             state, state_next;
    logic               sgn_q;
    logic [EXP_W-1:0]   exp_q;
    logic [MW-1:0]      mant_q;

    logic               accept;
    logic               norm_done;
    logic [EXP_W-1:0]   exp_inc;
    logic [EXP_W-1:0]   shift_exp;
    logic [MW-1:0]      shift_mant;
    logic [NUM_W-1:0]   res_num;
    logic               res_ovf;
    logic               res_unf;

`ifdef FLOAT_NORM_LZC_EN
    localparam int unsigned LZ_W = $clog2(MAN_W + 1);
    logic [LZ_W-1:0]    lz;
    logic [MAN_W-1:0]   mant_sh;

    // Leading zeros below the carry bit; the highest set bit wins
    always_comb begin
        lz = '0;
        for (int i = 0; i <= int'(MAN_W); i++) begin
            if (mant_q[i]) lz = LZ_W'(int'(MAN_W) - i);
        end
        mant_sh = MAN_W'(mant_q << lz);
    end
`endif

    assign in_ready = (state == IDLE) && !rst;
    assign accept   = in_valid && in_ready;
    assign exp_inc  = exp_q + EXP_W'(1);

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)    state_next = NORM;
            NORM:    if (norm_done) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default:                state_next = IDLE;
        endcase
    end

    // Normalization step, evaluated in priority order while in NORM
    always_comb begin
        norm_done  = 1'b0;
        res_num    = '0;
        res_ovf    = 1'b0;
        res_unf    = 1'b0;
        shift_exp  = exp_q;
        shift_mant = mant_q;
        if (mant_q == '0) begin
            norm_done = 1'b1;
        end else if (mant_q[MAN_W+1]) begin
            norm_done = 1'b1;
            if (exp_inc == '1) begin
                res_num = {sgn_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
                res_ovf = 1'b1;
            end else begin
                res_num = {sgn_q, exp_inc, mant_q[MAN_W:1]};
            end
        end else if (mant_q[MAN_W]) begin
            norm_done = 1'b1;
            res_num   = {sgn_q, exp_q, mant_q[MAN_W-1:0]};
        end else begin
`ifdef FLOAT_NORM_LZC_EN
            // Flushing happens exactly when the exponent would reach 1 before the hidden bit is set
            norm_done = 1'b1;
            if (32'(exp_q) <= 32'(lz)) begin
                res_num = {sgn_q, {(NUM_W-1){1'b0}}};
                res_unf = 1'b1;
            end else begin
                res_num = {sgn_q, exp_q - EXP_W'(lz), mant_sh};
            end
`else
            if (exp_q <= EXP_W'(1)) begin
                norm_done = 1'b1;
                res_num   = {sgn_q, {(NUM_W-1){1'b0}}};
                res_unf   = 1'b1;
            end else begin
                shift_mant = mant_q << 1;
                shift_exp  = exp_q - EXP_W'(1);
            end
`endif
        end
    end

    // Operand and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sgn_q     <= 1'b0;
            exp_q     <= '0;
            mant_q    <= '0;
            out_valid <= 1'b0;
            out_num   <= '0;
            out_ovf   <= 1'b0;
            out_unf   <= 1'b0;
        end else begin
            out_valid <= (state_next == DONE);
            if (accept) begin
                sgn_q   <= in_sign;
                exp_q   <= in_exp;
                mant_q  <= in_mant;
                out_ovf <= 1'b0;
                out_unf <= 1'b0;
            end
            if (state == NORM) begin
                exp_q  <= shift_exp;
                mant_q <= shift_mant;
                if (norm_done) begin
                    out_num <= res_num;
                    out_ovf <= res_ovf;
                    out_unf <= res_unf;
                end
            end
        end
    end

endmodule

// File: tb/tb_float_norm_pack.sv
// Directed self-checking bench for float_norm_pack (honours FLOAT_NORM_LZC_EN for latency expectations).
module tb_float_norm_pack;

`ifdef FLOAT_NORM_LZC_EN
    localparam bit LZC = 1'b1;
`else
    localparam bit LZC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_sign;
    logic [7:0]  in_exp;
    logic [24:0] in_mant;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_num;
    logic        out_ovf;
    logic        out_unf;

    int errors = 0;
    int checks = 0;

    float_norm_pack dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sign   (in_sign),
        .in_exp    (in_exp),
        .in_mant   (in_mant),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_num   (out_num),
        .out_ovf   (out_ovf),
        .out_unf   (out_unf)
    );

    always #5 clk = ~clk;

    // Present one operand and return right after the accept edge (or give up after a bound)
    task automatic send(input logic s, input logic [7:0] e, input logic [24:0] m);
        int n = 0;
        while (in_ready !== 1'b1 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        in_sign = s; in_exp = e; in_mant = m; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    // Cycles counted with the accept edge as cycle 1
    task automatic wait_valid(output int lat);
        lat = 1;
        while (out_valid !== 1'b1 && lat < 100) begin
            @(posedge clk); #1; lat++;
        end
    endtask

    task automatic pop();
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_sign = 1'b0; in_exp = '0; in_mant = '0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready got=%b exp=0", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid got=%b exp=0", out_valid); end
        checks++; if (out_num !== 32'h0) begin errors++; $display("FAIL rst_out_num got=%h exp=0", out_num); end
        checks++; if ({out_ovf, out_unf} !== 2'b00) begin errors++; $display("FAIL rst_flags got=%b exp=00", {out_ovf, out_unf}); end
        rst = 1'b0;
        #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_normalized();
        int lat;
        send(1'b0, 8'h80, 25'h0800000);
        wait_valid(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL norm_latency got=%0d exp=2", lat); end
        checks++; if (out_num !== 32'h40000000) begin errors++; $display("FAIL norm_num got=%h exp=40000000", out_num); end
        checks++; if ({out_ovf, out_unf} !== 2'b00) begin errors++; $display("FAIL norm_flags got=%b exp=00", {out_ovf, out_unf}); end
        pop();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL norm_pop_valid got=%b exp=0", out_valid); end
    endtask

    task automatic test_carry();
        int lat;
        send(1'b0, 8'h7F, 25'h1800000);
        wait_valid(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL carry_latency got=%0d exp=2", lat); end
        checks++; if (out_num !== 32'h40400000) begin errors++; $display("FAIL carry_num got=%h exp=40400000", out_num); end
        checks++; if ({out_ovf, out_unf} !== 2'b00) begin errors++; $display("FAIL carry_flags got=%b exp=00", {out_ovf, out_unf}); end
        pop();
    endtask

    task automatic test_left_shift();
        int lat;
        send(1'b0, 8'h85, 25'h0100000);
        wait_valid(lat);
        checks++; if (lat != (LZC ? 2 : 5)) begin errors++; $display("FAIL lshift_latency got=%0d exp=%0d", lat, LZC ? 2 : 5); end
        checks++; if (out_num !== 32'h41000000) begin errors++; $display("FAIL lshift_num got=%h exp=41000000", out_num); end
        checks++; if ({out_ovf, out_unf} !== 2'b00) begin errors++; $display("FAIL lshift_flags got=%b exp=00", {out_ovf, out_unf}); end
        pop();
    endtask

    task automatic test_zero_and_overflow();
        int lat;
        send(1'b1, 8'h40, 25'h0000000);
        wait_valid(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL zero_latency got=%0d exp=2", lat); end
        checks++; if (out_num !== 32'h00000000) begin errors++; $display("FAIL zero_num got=%h exp=00000000", out_num); end
        checks++; if ({out_ovf, out_unf} !== 2'b00) begin errors++; $display("FAIL zero_flags got=%b exp=00", {out_ovf, out_unf}); end
        pop();
        send(1'b0, 8'hFE, 25'h1000000);
        wait_valid(lat);
        checks++; if (out_num !== 32'h7F800000) begin errors++; $display("FAIL ovf_num got=%h exp=7F800000", out_num); end
        checks++; if ({out_ovf, out_unf} !== 2'b10) begin errors++; $display("FAIL ovf_flags got=%b exp=10", {out_ovf, out_unf}); end
        pop();
    endtask

    task automatic test_underflow_hold();
        int lat;
        send(1'b1, 8'h05, 25'h0000001);
        wait_valid(lat);
        checks++; if (lat != (LZC ? 2 : 6)) begin errors++; $display("FAIL unf_latency got=%0d exp=%0d", lat, LZC ? 2 : 6); end
        checks++; if (out_num !== 32'h80000000) begin errors++; $display("FAIL unf_num got=%h exp=80000000", out_num); end
        checks++; if ({out_ovf, out_unf} !== 2'b01) begin errors++; $display("FAIL unf_flags got=%b exp=01", {out_ovf, out_unf}); end
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL hold_valid cyc=%0d got=%b exp=1", c, out_valid); end
            checks++; if (out_num !== 32'h80000000) begin errors++; $display("FAIL hold_num cyc=%0d got=%h exp=80000000", c, out_num); end
            checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL hold_in_ready cyc=%0d got=%b exp=0", c, in_ready); end
        end
        pop();
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL hold_release_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL hold_release_in_ready got=%b exp=1", in_ready); end
    endtask

    task automatic test_reset_mid_op();
        int lat;
        send(1'b0, 8'h85, 25'h0100000);
        rst = 1'b1;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got=%b exp=0", out_valid); end
        checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL midrst_in_ready got=%b exp=0", in_ready); end
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL midrst_release_in_ready got=%b exp=1", in_ready); end
        repeat (6) begin
            @(posedge clk); #1;
            checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_no_result got=%b exp=0", out_valid); end
        end
        send(1'b0, 8'h80, 25'h0800000);
        wait_valid(lat);
        checks++; if (lat != 2) begin errors++; $display("FAIL post_rst_latency got=%0d exp=2", lat); end
        checks++; if (out_num !== 32'h40000000) begin errors++; $display("FAIL post_rst_num got=%h exp=40000000", out_num); end
        pop();
    endtask

    initial begin
        test_reset();
        test_normalized();
        test_carry();
        test_left_shift();
        test_zero_and_overflow();
        test_underflow_hold();
        test_reset_mid_op();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
